// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline stage register.
// Holds the decoded control bundle (WB, M, EX) and the operand, immediate and
// register-address fields for the EX stage. It also detects load-use hazards
// and inserts bubbles, handles flush and downstream stall, and keeps a
// saturating count of the load-use bubbles it has inserted.
module id_ex_pipe_reg #(
   parameter int DATA_W  = 32,
   parameter int REG_W   = 5,
   parameter int WB_W    = 2,
   parameter int M_W     = 2,
   parameter int EX_W    = 4,
   parameter int MRD_BIT = 1,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              startin,
   input  logic              in_valid,
   input  logic [WB_W-1:0]   id_wb,
   input  logic [M_W-1:0]    id_m,
   input  logic [EX_W-1:0]   id_ex,
   input  logic [DATA_W-1:0] id_rs_val,
   input  logic [DATA_W-1:0] id_rt_val,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic              flush,
   input  logic              ex_stall,
   output logic              ex_valid,
   output logic [WB_W-1:0]   ex_wb,
   output logic [M_W-1:0]    ex_m,
   output logic [EX_W-1:0]   ex_ex,
   output logic [DATA_W-1:0] ex_rs_val,
   output logic [DATA_W-1:0] ex_rt_val,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_W-1:0]  ex_rs,
   output logic [REG_W-1:0]  ex_rt,
   output logic [REG_W-1:0]  ex_rd,
   output logic              stall_up,
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic load_use;
   logic src_match;

   // Load-use hazard: a valid load in EX whose destination (rt, never r0)
   // feeds either source field of the instruction in ID. Both source fields
   // are compared regardless of whether the consumer actually uses rt.
   always_comb begin
      src_match = (ex_rt == id_rs) || (ex_rt == id_rt);
      load_use  = startin && in_valid && ex_valid && ex_m[MRD_BIT] &&
                  (ex_rt != '0) && src_match;
      stall_up  = startin && (load_use || ex_stall);
   end

   // Stage register update; priority: reset, flush, stall hold, load-use
   // bubble, normal load.
   always_ff @(posedge clk) begin
      if (!startin) begin
         ex_valid   <= 1'b0;
         ex_wb      <= '0;
         ex_m       <= '0;
         ex_ex      <= '0;
         ex_rs_val  <= '0;
         ex_rt_val  <= '0;
         ex_imm     <= '0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_rd      <= '0;
         bubble_cnt <= '0;
      end else if (flush) begin
         ex_valid   <= 1'b0;
         ex_wb      <= '0;
         ex_m       <= '0;
         ex_ex      <= '0;
         ex_rs_val  <= id_rs_val;
         ex_rt_val  <= id_rt_val;
         ex_imm     <= id_imm;
         ex_rs      <= id_rs;
         ex_rt      <= id_rt;
         ex_rd      <= id_rd;
      end else if (ex_stall) begin
         // EX is held by the downstream stage: every register keeps its value.
      end else if (load_use) begin
         ex_valid   <= 1'b0;
         ex_wb      <= '0;
         ex_m       <= '0;
         ex_ex      <= '0;
         ex_rs_val  <= id_rs_val;
         ex_rt_val  <= id_rt_val;
         ex_imm     <= id_imm;
         ex_rs      <= id_rs;
         ex_rt      <= id_rt;
         ex_rd      <= id_rd;
         if (bubble_cnt != '1) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
         end
      end else begin
         ex_valid   <= in_valid;
         ex_wb      <= in_valid ? id_wb : '0;
         ex_m       <= in_valid ? id_m  : '0;
         ex_ex      <= in_valid ? id_ex : '0;
         ex_rs_val  <= id_rs_val;
         ex_rt_val  <= id_rt_val;
         ex_imm     <= id_imm;
         ex_rs      <= id_rs;
         ex_rt      <= id_rt;
         ex_rd      <= id_rd;
      end
   end

endmodule
